// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - descriptor layout and sizing constants for sprite_compositor
package sprite_pkg;

  // Descriptor field positions
  localparam int ENABLE_BIT = 31;
  localparam int FLIP_BIT   = 26;
  localparam int RSVD_MSB   = 30;
  localparam int RSVD_LSB   = 27;
  localparam int POSX_MSB   = 25;
  localparam int POSX_LSB   = 16;
  localparam int POSY_MSB   = 15;
  localparam int POSY_LSB   = 6;
  localparam int ROW_MSB    = 5;
  localparam int ROW_LSB    = 3;
  localparam int COL_MSB    = 2;
  localparam int COL_LSB    = 0;

  localparam int DESC_W     = 32;

  // Default sprite geometry
  localparam int DEF_SPR_W  = 32;
  localparam int DEF_SPR_H  = 32;

  // ROM address layout: {row, dy, col, dx}
  localparam int ROM_FIELD_W = 5;
  localparam int ROM_SEL_W   = 3;
  localparam int ROM_ADDR_W  = 2 * (ROM_SEL_W + ROM_FIELD_W);

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - descriptor write, pixel scan and result bundle
interface sprite_compositor_if;
  import sprite_pkg::*;

  logic                  wea;
  logic [2:0]            addr;
  logic [DESC_W-1:0]     dina;
  logic                  frame_start;
  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic                  video_on;
  logic                  pix_valid;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [2:0]            slot_id;
  logic                  collision;
  logic [7:0]            collision_slots;

  modport master (
    output wea, addr, dina, frame_start, h_cnt, v_cnt, video_on,
    input  pix_valid, rom_addr, slot_id, collision, collision_slots
  );

  modport slave (
    input  wea, addr, dina, frame_start, h_cnt, v_cnt, video_on,
    output pix_valid, rom_addr, slot_id, collision, collision_slots
  );

endinterface

// File: rtl/sprite_hit_unit.sv
// rtl/sprite_hit_unit.sv - per-slot bounds test and ROM address; SPRITE_FLIP_EN adds horizontal mirroring
module sprite_hit_unit
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic [DESC_W-1:0]     i_desc,
  input  logic [9:0]            i_h_cnt,
  input  logic [9:0]            i_v_cnt,
  input  logic                  i_video_on,
  output logic                  o_hit,
  output logic [ROM_ADDR_W-1:0] o_rom_addr
);

  localparam int DX_W = $clog2(SPR_W);
  localparam int DY_W = $clog2(SPR_H);

  // 11-bit operands so a sprite near the right/bottom edge never wraps to 0
  logic [10:0]            w_pos_x;
  logic [10:0]            w_pos_y;
  logic [10:0]            w_h;
  logic [10:0]            w_v;
  logic                   w_in_x;
  logic                   w_in_y;
  logic [DX_W-1:0]        w_dx_raw;
  logic [DX_W-1:0]        w_dx;
  logic [DY_W-1:0]        w_dy;
  logic                   w_unused;

  assign w_pos_x = {1'b0, i_desc[POSX_MSB:POSX_LSB]};
  assign w_pos_y = {1'b0, i_desc[POSY_MSB:POSY_LSB]};
  assign w_h     = {1'b0, i_h_cnt};
  assign w_v     = {1'b0, i_v_cnt};

  assign w_in_x = (w_h >= w_pos_x) && (w_h < w_pos_x + 11'(SPR_W));
  assign w_in_y = (w_v >= w_pos_y) && (w_v < w_pos_y + 11'(SPR_H));
  assign o_hit  = i_desc[ENABLE_BIT] && i_video_on && w_in_x && w_in_y;

  // Offsets only need the low bits, so subtract in the truncated width
  assign w_dx_raw = i_h_cnt[DX_W-1:0] - i_desc[POSX_LSB +: DX_W];
  assign w_dy     = i_v_cnt[DY_W-1:0] - i_desc[POSY_LSB +: DY_W];

`ifdef SPRITE_FLIP_EN
  assign w_dx     = i_desc[FLIP_BIT] ? (DX_W'(SPR_W - 1) - w_dx_raw) : w_dx_raw;
  assign w_unused = ^i_desc[RSVD_MSB:RSVD_LSB];
`else
  assign w_dx     = w_dx_raw;
  assign w_unused = ^{i_desc[RSVD_MSB:RSVD_LSB], i_desc[FLIP_BIT]};
`endif

  assign o_rom_addr = {i_desc[ROW_MSB:ROW_LSB], ROM_FIELD_W'(w_dy),
                       i_desc[COL_MSB:COL_LSB], ROM_FIELD_W'(w_dx)};

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - sprite table, 2-stage hit/priority pipeline, slot-0 collision flags; SPRITE_FLIP_EN enables mirroring
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int SPR_W     = DEF_SPR_W,
  parameter int SPR_H     = DEF_SPR_H,
  parameter int NUM_SLOTS = 8
) (
  input  logic                clk,
  input  logic                reset,
  sprite_compositor_if.slave  bus
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [DESC_W-1:0]     r_shadow [NUM_SLOTS];
  logic [DESC_W-1:0]     r_active [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  w_hit;
  logic [NUM_SLOTS-1:0]  r_hit;
  logic [ROM_ADDR_W-1:0] w_rom [NUM_SLOTS];
  logic [ROM_ADDR_W-1:0] r_rom [NUM_SLOTS];
  logic                  w_win_valid;
  logic [SLOT_W-1:0]     w_win_id;
  logic [ROM_ADDR_W-1:0] w_win_rom;
  logic                  r_pix_valid;
  logic [SLOT_W-1:0]     r_slot_id;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  logic [NUM_SLOTS-1:0]  w_coll_now;
  logic [NUM_SLOTS-1:0]  r_coll_acc;
  logic [NUM_SLOTS-1:0]  r_coll_slots;
  logic                  r_collision;

  // Shadow takes writes any time; active copies the pre-write shadow on frame_start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (bus.frame_start) r_active <= r_shadow;
      if (bus.wea)         r_shadow[bus.addr] <= bus.dina;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .i_desc     (r_active[g]),
      .i_h_cnt    (bus.h_cnt),
      .i_v_cnt    (bus.v_cnt),
      .i_video_on (bus.video_on),
      .o_hit      (w_hit[g]),
      .o_rom_addr (w_rom[g])
    );
  end

  // Stage 1: capture every slot's hit and candidate ROM address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_rom[i] <= '0;
    end else begin
      r_hit <= w_hit;
      r_rom <= w_rom;
    end
  end

  // Lowest-numbered hitting slot wins; scanning downward leaves the lowest assignment
  always_comb begin
    w_win_valid = 1'b0;
    w_win_id    = '0;
    w_win_rom   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (r_hit[i]) begin
        w_win_valid = 1'b1;
        w_win_id    = SLOT_W'(i);
        w_win_rom   = r_rom[i];
      end
    end
  end

  // Stage 2: registered winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pix_valid <= 1'b0;
      r_slot_id   <= '0;
      r_rom_addr  <= '0;
    end else begin
      r_pix_valid <= w_win_valid;
      r_slot_id   <= w_win_id;
      r_rom_addr  <= w_win_rom;
    end
  end

  // Player (slot 0) overlap with any other slot in the current stage-1 result
  assign w_coll_now = r_hit[0] ? (r_hit & ~NUM_SLOTS'(1)) : '0;

  // Accumulate per frame; a hit coincident with frame_start seeds the new frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coll_acc   <= '0;
      r_coll_slots <= '0;
      r_collision  <= 1'b0;
    end else if (bus.frame_start) begin
      r_coll_slots <= r_coll_acc;
      r_collision  <= |r_coll_acc;
      r_coll_acc   <= w_coll_now;
    end else begin
      r_coll_acc   <= r_coll_acc | w_coll_now;
    end
  end

  assign bus.pix_valid       = r_pix_valid;
  assign bus.slot_id         = r_slot_id;
  assign bus.rom_addr        = r_rom_addr;
  assign bus.collision       = r_collision;
  assign bus.collision_slots = r_coll_slots;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - directed and randomized checks of sprite_compositor against a per-pixel model
module tb_sprite_compositor;
  import sprite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  sprite_compositor_if bus();

  sprite_compositor dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: descriptor tables, one-pixel-delayed result, collision bookkeeping
  logic [31:0] sh [8];
  logic [31:0] ac [8];
  logic [7:0]  acc, m_cs, p1_mask;
  logic        m_pv, p1_pv;
  logic [2:0]  m_slot, p1_slot;
  logic [15:0] m_rom, p1_rom;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input bit en, input bit flip, input int x, input int y,
                                     input int row, input int col);
    logic [31:0] d;
    d = '0;
    d[31]    = en;
    d[26]    = flip;
    d[25:16] = 10'(x);
    d[15:6]  = 10'(y);
    d[5:3]   = 3'(row);
    d[2:0]   = 3'(col);
    return d;
  endfunction

  function automatic logic [7:0] coll(input logic [7:0] m);
    return m[0] ? (m & 8'hFE) : 8'h00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      sh[i] = '0;
      ac[i] = '0;
    end
    acc = 0; m_cs = 0; p1_mask = 0;
    m_pv = 0; p1_pv = 0; m_slot = 0; p1_slot = 0; m_rom = 0; p1_rom = 0;
  endtask

  // One clock of the behavioural model, using the inputs the DUT just sampled
  task automatic model_edge();
    logic [7:0]  mask;
    logic        pv;
    logic [2:0]  sl;
    logic [15:0] rom;
    m_pv = p1_pv; m_slot = p1_slot; m_rom = p1_rom;
    if (bus.frame_start) begin
      m_cs = acc;
      acc  = coll(p1_mask);
    end else begin
      acc  = acc | coll(p1_mask);
    end
    mask = 0; pv = 0; sl = 0; rom = 0;
    for (int s = 7; s >= 0; s--) begin
      int px, py, h, v, dx, dy;
      logic [31:0] d;
      d  = ac[s];
      px = int'(d[25:16]);
      py = int'(d[15:6]);
      h  = int'(bus.h_cnt);
      v  = int'(bus.v_cnt);
      if (d[31] && bus.video_on && h >= px && h < px + 32 && v >= py && v < py + 32) begin
        dx = h - px;
        dy = v - py;
`ifdef SPRITE_FLIP_EN
        if (d[26]) dx = 31 - dx;
`endif
        mask[s] = 1'b1;
        pv      = 1'b1;
        sl      = 3'(s);
        rom     = 16'(d[5:3]) * 16'd8192 + 16'(dy) * 16'd256 + 16'(d[2:0]) * 16'd32 + 16'(dx);
      end
    end
    p1_mask = mask; p1_pv = pv; p1_slot = sl; p1_rom = rom;
    if (bus.frame_start)
      for (int i = 0; i < 8; i++) ac[i] = sh[i];
    if (bus.wea) sh[bus.addr] = bus.dina;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("pix_valid", 32'(bus.pix_valid), 32'(m_pv));
    check("slot_id", 32'(bus.slot_id), 32'(m_slot));
    check("rom_addr", 32'(bus.rom_addr), 32'(m_rom));
    check("collision_slots", 32'(bus.collision_slots), 32'(m_cs));
    check("collision", 32'(bus.collision), 32'(|m_cs));
    bus.wea = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wea = 1'b1; bus.addr = 3'(a); bus.dina = d;
    tick();
  endtask

  task automatic fs();
    bus.frame_start = 1'b1;
    tick();
  endtask

  // Hold a pixel long enough that the outputs correspond to it
  task automatic probe(input int h, input int v);
    bus.h_cnt = 10'(h); bus.v_cnt = 10'(v); bus.video_on = 1'b1;
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pv"}, 32'(bus.pix_valid), 32'd0);
    check({tag, "_slot"}, 32'(bus.slot_id), 32'd0);
    check({tag, "_rom"}, 32'(bus.rom_addr), 32'd0);
    check({tag, "_coll"}, 32'(bus.collision), 32'd0);
    check({tag, "_cs"}, 32'(bus.collision_slots), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          s;
    reset = 1'b0;
    bus.wea = 0; bus.addr = 0; bus.dina = 0; bus.frame_start = 0;
    bus.h_cnt = 0; bus.v_cnt = 0; bus.video_on = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    // Write without commit: nothing visible
    wr(0, mk(1, 0, 80, 400, 0, 2));
    probe(80, 400);
    check("uncommitted_pv", 32'(bus.pix_valid), 32'd0);
    fs();
    probe(80, 400);
    check("slot0_pv", 32'(bus.pix_valid), 32'd1);
    check("slot0_id", 32'(bus.slot_id), 32'd0);
    check("slot0_rom", 32'(bus.rom_addr), 32'h0040);
    probe(111, 431);
    check("slot0_corner_rom", 32'(bus.rom_addr), 32'h1F5F);
    probe(112, 400);
    check("slot0_right_edge", 32'(bus.pix_valid), 32'd0);

    // Write coinciding with frame_start waits one more frame
    bus.wea = 1'b1; bus.addr = 3'd1; bus.dina = mk(1, 0, 500, 100, 1, 1);
    fs();
    probe(500, 100);
    check("same_cycle_hidden", 32'(bus.pix_valid), 32'd0);
    fs();
    probe(500, 100);
    check("same_cycle_shown", 32'(bus.pix_valid), 32'd1);
    check("same_cycle_id", 32'(bus.slot_id), 32'd1);

    // Overlap of slots 0 and 3, then collision report and its clearing
    wr(3, mk(1, 0, 85, 405, 2, 3));
    fs();
    fs();
    probe(90, 410);
    check("overlap_id", 32'(bus.slot_id), 32'd0);
    bus.video_on = 1'b0;
    tick();
    tick();
    fs();
    check("collision_set", 32'(bus.collision), 32'd1);
    check("collision_slots_set", 32'(bus.collision_slots), 32'h08);
    repeat (3) tick();
    fs();
    check("collision_clear", 32'(bus.collision), 32'd0);

    // Right-edge sprite does not wrap
    wr(5, mk(1, 0, 1000, 0, 0, 0));
    fs();
    probe(1023, 5);
    check("edge_1023_pv", 32'(bus.pix_valid), 32'd1);
    check("edge_1023_id", 32'(bus.slot_id), 32'd5);
    for (int h = 0; h < 8; h++) probe(h, 5);
    probe(0, 5);
    check("edge_nowrap", 32'(bus.pix_valid), 32'd0);

    // Flip bit: mirrored only when the feature is built in
    wr(6, mk(1, 1, 300, 300, 0, 0));
    fs();
    probe(300, 300);
`ifdef SPRITE_FLIP_EN
    check("flip_dx", 32'(bus.rom_addr[4:0]), 32'd31);
`else
    check("flip_dx", 32'(bus.rom_addr[4:0]), 32'd0);
`endif

    // Randomized traffic aimed at sprite neighbourhoods
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        d = $urandom;
        d[31] = ($urandom_range(0, 3) != 0);
        bus.wea = 1'b1; bus.addr = 3'($urandom_range(0, 7)); bus.dina = d;
      end
      if ($urandom_range(0, 31) == 0) bus.frame_start = 1'b1;
      s = $urandom_range(0, 7);
      bus.h_cnt = 10'(int'(sh[s][25:16]) + int'($urandom_range(0, 40)) - 4);
      bus.v_cnt = 10'(int'(sh[s][15:6]) + int'($urandom_range(0, 40)) - 4);
      bus.video_on = ($urandom_range(0, 7) != 0);
      tick();
    end

    // Asynchronous reset in the middle of a visible sprite
    wr(0, mk(1, 0, 80, 400, 0, 2));
    fs();
    fs();
    probe(80, 400);
    check("pre_reset_pv", 32'(bus.pix_valid), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    probe(80, 400);
    check("post_reset_empty", 32'(bus.pix_valid), 32'd0);
    wr(0, mk(1, 0, 80, 400, 0, 2));
    probe(80, 400);
    check("post_reset_uncommitted", 32'(bus.pix_valid), 32'd0);
    fs();
    probe(80, 400);
    check("post_reset_shown", 32'(bus.pix_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream of the player and obstacle controllers. Each controller writes 32-bit sprite descriptors (addr/dina) into an 8-slot attribute table.
- Per VGA pixel, the block resolves which enabled sprite covers the pixel, lowest slot wins, and emits the sprite-sheet ROM address for the pixel mux.
- It also flags, once per frame, any pixel overlap between slot 0 (player) and any other slot, for the game-over logic.

Parameters:
- SPR_W, 32, sprite width in pixels; power of 2, max 32
- SPR_H, 32, sprite height in pixels; power of 2, max 32
- NUM_SLOTS, 8, descriptor slots; must equal 2^width(addr)

Ports:
- clk  in  1  system clock (pixel-enable domain)
- reset  in  1  asynchronous, active-low reset
- wea  in  1  descriptor write strobe
- addr  in  3  slot index for the write
- dina  in  32  descriptor: [31] enable, [30:27] reserved, [26] flip, [25:16] pos_x, [15:6] pos_y, [5:3] rom_row, [2:0] rom_col
- frame_start  in  1  one-cycle pulse at start of frame (from VGA timing)
- h_cnt  in  10  current pixel x
- v_cnt  in  10  current pixel y
- video_on  in  1  visible region
- pix_valid  out  1  a sprite covers the pixel (2 cycles after h_cnt/v_cnt)
- rom_addr  out  16  {rom_row, dy[4:0], rom_col, dx[4:0]}
- slot_id  out  3  winning slot
- collision  out  1  slot-0 overlap seen in previous frame
- collision_slots  out  8  bit i set if slot i overlapped slot 0 in previous frame; bit 0 always 0

Behaviour:
- Storage: shadow table (written by wea) and active table (used for hit test), NUM_SLOTS x 32 each. Reset clears both to 0, so all slots are disabled.
- Write: on wea, shadow[addr] <= dina. No back-pressure; a write is accepted every cycle.
- Commit: on frame_start, active <= shadow in one cycle, so sprites never tear mid-frame.
  - If wea and frame_start occur in the same cycle, the copy takes the pre-write shadow contents. The new write is held until the next frame_start.
- Stage 1 (registered), for every slot i:
  - hit_i = enable && video_on && h_cnt >= pos_x && h_cnt < pos_x+SPR_W && v_cnt >= pos_y && v_cnt < pos_y+SPR_H.
  - The comparison uses 11-bit sums, so pos_x+SPR_W > 1023 does not wrap.
  - dx_i = h_cnt-pos_x and dy_i = v_cnt-pos_y, truncated to log2(SPR_W) and log2(SPR_H) bits.
- Stage 2 (registered):
  - Priority encode: lowest hit index wins.
  - pix_valid = OR(hit); slot_id = winning index.
  - rom_addr is built from the winner's rom_row/rom_col/dy/dx, zero-extended into the 5-bit fields.
  - If no hit: pix_valid = 0, rom_addr = 0, slot_id = 0.
- Latency: exactly 2 clk from h_cnt/v_cnt/video_on to outputs, with no bubbles.
- Collision accumulator:
  - coll_acc[i] sets when hit_0 && hit_i (i > 0) in the same stage-1 result.
  - On frame_start, collision_slots <= coll_acc, collision <= |coll_acc, and coll_acc clears.
  - A hit arriving in the same cycle as frame_start goes into the new accumulator.
- Reset mid-frame: all outputs 0 immediately (asynchronous). Tables are cleared; sprites reappear only after they are rewritten and a frame_start occurs.
- Reserved bits [30:27] are ignored.

Optional Feature:
- SPRITE_FLIP_EN defined: when descriptor bit 26 = 1, the dx field is replaced by (SPR_W-1-dx), giving horizontal mirroring.
- Undefined: bit 26 is ignored, and no flip logic is synthesized.

Decomposition:
- Package sprite_pkg:
  - descriptor field bit positions (ENABLE_BIT, FLIP_BIT, POSX_MSB/LSB, POSY_MSB/LSB, ROW_MSB/LSB, COL_MSB/LSB)
  - default SPR_W/SPR_H
  - ROM address field widths
- One sub-module, sprite_hit_unit: per-slot bounds compare and dx/dy computation, instantiated NUM_SLOTS times via generate.
- Table, priority encoder and collision accumulator stay in the top level.

Test Plan:
- Write slot 0 = {en=1, x=80, y=400, row=0, col=2}, pulse frame_start, scan h=80, v=400 -> 2 cycles later pix_valid=1, slot_id=0, rom_addr=0x0040. At h=112: pix_valid=0.
- Write slot 0 without frame_start -> no pix_valid anywhere. After frame_start -> sprite appears. Write with wea and frame_start in the same cycle -> sprite appears only after the following frame_start.
- Slots 0 and 3 both enabled and overlapping at (90,410) -> slot_id=0 there. At the next frame_start -> collision=1, collision_slots=8'b0000_1000. One frame later with no overlap -> collision=0.
- Slot 5 at x=1000 -> hits for h=1000..1023 only, no wrap to h=0..7.
- With SPRITE_FLIP_EN, descriptor bit26=1, pixel h=pos_x -> dx field=31. Without the macro -> dx field=0.
- Assert reset low mid-scan while pix_valid=1 -> all outputs 0 in the same cycle. After release, no sprites until rewrite + frame_start.
